// File: rtl/m68k_bus_master_pkg.sv
// Shared definitions for the 68000 bus master: state encoding, function codes,
// timeout default and byte-enable normalisation.
package m68k_bus_master_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_REQ   = 3'd1,
        ST_GRANT = 3'd2,
        ST_ADDR  = 3'd3,
        ST_STRB  = 3'd4,
        ST_WAIT  = 3'd5,
        ST_END   = 3'd6,
        ST_HOLD  = 3'd7
    } state_e;

    // Function codes shared with the glue logic decoder.
    localparam logic [2:0] FC_USER_DATA = 3'b001;
    localparam logic [2:0] FC_USER_PROG = 3'b010;
    localparam logic [2:0] FC_SUPV_DATA = 3'b101;
    localparam logic [2:0] FC_SUPV_PROG = 3'b110;
    localparam logic [2:0] FC_IACK      = 3'b111;

    localparam int TIMEOUT_CYCLES_DEF = 64;

    // An all-zero enable is meaningless on the bus; run it as a word access.
    function automatic logic [1:0] norm_be(input logic [1:0] be_in);
        return (be_in == 2'b00) ? 2'b11 : be_in;
    endfunction

endpackage

// File: rtl/m68k_bus_master_sync2.sv
// Two-flop synchronizer for asynchronous 68000 bus inputs; resets to the
// negated (high) level.
module m68k_bus_master_sync2 (
    input  logic clk_i,
    input  logic rst_n_i,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    // Two-stage capture of the asynchronous input.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            meta_q <= 1'b1;
            sync_q <= 1'b1;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/m68k_bus_master.sv
// 68000 bus initiator: arbitrates via BR/BG/BGACK and runs one word/byte cycle
// per request. Define M68K_BUS_MASTER_TIMEOUT_EN to abort cycles lacking DTACK/BERR.
module m68k_bus_master
    import m68k_bus_master_pkg::*;
#(
    parameter logic [2:0] FC_CODE = FC_SUPV_DATA
`ifdef M68K_BUS_MASTER_TIMEOUT_EN
    ,
    parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
`endif
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        req,
    input  logic        we,
    input  logic [22:0] addr,
    input  logic [1:0]  be,
    input  logic [15:0] wdata,
    output logic        ack,
    output logic        err,
    output logic [15:0] rdata,
    output logic        br_n,
    input  logic        bg_n,
    output logic        bgack_n,
    output logic        as_n,
    output logic        uds_n,
    output logic        lds_n,
    output logic        rw,
    output logic [2:0]  fc,
    output logic [22:0] a,
    output logic [15:0] d_out,
    input  logic [15:0] d_in,
    output logic        bus_oe,
    output logic        d_oe,
    input  logic        as_in_n,
    input  logic        dtack_n,
    input  logic        berr_n
);

    logic bg_s, as_in_s, dtack_s, berr_s;

    m68k_bus_master_sync2 u_sync_bg    (.clk_i(clk), .rst_n_i(reset_n), .d_i(bg_n),    .q_o(bg_s));
    m68k_bus_master_sync2 u_sync_as    (.clk_i(clk), .rst_n_i(reset_n), .d_i(as_in_n), .q_o(as_in_s));
    m68k_bus_master_sync2 u_sync_dtack (.clk_i(clk), .rst_n_i(reset_n), .d_i(dtack_n), .q_o(dtack_s));
    m68k_bus_master_sync2 u_sync_berr  (.clk_i(clk), .rst_n_i(reset_n), .d_i(berr_n),  .q_o(berr_s));

    state_e      state_q, state_d;
    logic        we_q, we_d;
    logic [22:0] addr_q, addr_d;
    logic [1:0]  be_q, be_d;
    logic [15:0] wdata_q, wdata_d;
    logic        br_n_q, br_n_d, bgack_n_q, bgack_n_d;
    logic        as_n_q, as_n_d, uds_n_q, uds_n_d, lds_n_q, lds_n_d;
    logic        rw_q, rw_d;
    logic [2:0]  fc_q, fc_d;
    logic [22:0] a_q, a_d;
    logic [15:0] d_out_q, d_out_d;
    logic        bus_oe_q, bus_oe_d, d_oe_q, d_oe_d;
    logic        ack_q, ack_d, err_q, err_d;
    logic [15:0] rdata_q, rdata_d;
    logic [15:0] capt_q, capt_d;
    logic        err_pend_q, err_pend_d;
`ifdef M68K_BUS_MASTER_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);
    logic [TMO_W-1:0] tmo_cnt_q, tmo_cnt_d;
`endif

    // Next-state and next-output logic; outputs change on state entry.
    always_comb begin
        state_d    = state_q;
        we_d       = we_q;
        addr_d     = addr_q;
        be_d       = be_q;
        wdata_d    = wdata_q;
        br_n_d     = br_n_q;
        bgack_n_d  = bgack_n_q;
        as_n_d     = as_n_q;
        uds_n_d    = uds_n_q;
        lds_n_d    = lds_n_q;
        rw_d       = rw_q;
        fc_d       = fc_q;
        a_d        = a_q;
        d_out_d    = d_out_q;
        bus_oe_d   = bus_oe_q;
        d_oe_d     = d_oe_q;
        ack_d      = 1'b0;
        err_d      = err_q;
        rdata_d    = rdata_q;
        capt_d     = capt_q;
        err_pend_d = err_pend_q;
`ifdef M68K_BUS_MASTER_TIMEOUT_EN
        tmo_cnt_d  = tmo_cnt_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (req) begin
                    we_d    = we;
                    addr_d  = addr;
                    be_d    = norm_be(be);
                    wdata_d = wdata;
                    br_n_d  = 1'b0;
                    state_d = ST_REQ;
                end else begin
                    br_n_d  = 1'b1;
                end
            end
            ST_REQ: begin
                // Take the bus only once the CPU has finished its own cycle.
                if (!bg_s && as_in_s && dtack_s) begin
                    bgack_n_d = 1'b0;
                    br_n_d    = 1'b1;
                    bus_oe_d  = 1'b1;
                    state_d   = ST_GRANT;
                end else begin
                    br_n_d    = 1'b0;
                end
            end
            ST_GRANT: begin
                a_d     = addr_q;
                fc_d    = FC_CODE;
                rw_d    = ~we_q;
                d_oe_d  = we_q;
                d_out_d = we_q ? wdata_q : d_out_q;
                state_d = ST_ADDR;
            end
            ST_ADDR: begin
                as_n_d  = 1'b0;
                uds_n_d = ~be_q[1];
                lds_n_d = ~be_q[0];
`ifdef M68K_BUS_MASTER_TIMEOUT_EN
                tmo_cnt_d = '0;
`endif
                state_d = ST_STRB;
            end
            ST_STRB: begin
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (!berr_s) begin
                    err_pend_d = 1'b1;
                    as_n_d     = 1'b1;
                    uds_n_d    = 1'b1;
                    lds_n_d    = 1'b1;
                    state_d    = ST_END;
                end else if (!dtack_s) begin
                    err_pend_d = 1'b0;
                    capt_d     = we_q ? capt_q : d_in;
                    as_n_d     = 1'b1;
                    uds_n_d    = 1'b1;
                    lds_n_d    = 1'b1;
                    state_d    = ST_END;
`ifdef M68K_BUS_MASTER_TIMEOUT_EN
                end else if (tmo_cnt_q == TMO_LAST) begin
                    err_pend_d = 1'b1;
                    as_n_d     = 1'b1;
                    uds_n_d    = 1'b1;
                    lds_n_d    = 1'b1;
                    state_d    = ST_END;
                end else begin
                    tmo_cnt_d  = tmo_cnt_q + 1'b1;
                end
`else
                end else begin
                    state_d    = ST_WAIT;
                end
`endif
            end
            ST_END: begin
                ack_d   = 1'b1;
                err_d   = err_pend_q;
                rdata_d = (!we_q && !err_pend_q) ? capt_q : rdata_q;
                d_oe_d  = 1'b0;
                state_d = ST_HOLD;
            end
            ST_HOLD: begin
                // Chain the next request without giving the bus back.
                if (req) begin
                    we_d    = we;
                    addr_d  = addr;
                    be_d    = norm_be(be);
                    wdata_d = wdata;
                    a_d     = addr;
                    fc_d    = FC_CODE;
                    rw_d    = ~we;
                    d_oe_d  = we;
                    d_out_d = we ? wdata : d_out_q;
                    state_d = ST_ADDR;
                end else begin
                    bgack_n_d = 1'b1;
                    bus_oe_d  = 1'b0;
                    state_d   = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and registered bus outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_IDLE;
            we_q       <= 1'b0;
            addr_q     <= 23'd0;
            be_q       <= 2'b11;
            wdata_q    <= 16'd0;
            br_n_q     <= 1'b1;
            bgack_n_q  <= 1'b1;
            as_n_q     <= 1'b1;
            uds_n_q    <= 1'b1;
            lds_n_q    <= 1'b1;
            rw_q       <= 1'b1;
            fc_q       <= 3'b000;
            a_q        <= 23'd0;
            d_out_q    <= 16'd0;
            bus_oe_q   <= 1'b0;
            d_oe_q     <= 1'b0;
            ack_q      <= 1'b0;
            err_q      <= 1'b0;
            rdata_q    <= 16'd0;
            capt_q     <= 16'd0;
            err_pend_q <= 1'b0;
`ifdef M68K_BUS_MASTER_TIMEOUT_EN
            tmo_cnt_q  <= '0;
`endif
        end else begin
            state_q    <= state_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            be_q       <= be_d;
            wdata_q    <= wdata_d;
            br_n_q     <= br_n_d;
            bgack_n_q  <= bgack_n_d;
            as_n_q     <= as_n_d;
            uds_n_q    <= uds_n_d;
            lds_n_q    <= lds_n_d;
            rw_q       <= rw_d;
            fc_q       <= fc_d;
            a_q        <= a_d;
            d_out_q    <= d_out_d;
            bus_oe_q   <= bus_oe_d;
            d_oe_q     <= d_oe_d;
            ack_q      <= ack_d;
            err_q      <= err_d;
            rdata_q    <= rdata_d;
            capt_q     <= capt_d;
            err_pend_q <= err_pend_d;
`ifdef M68K_BUS_MASTER_TIMEOUT_EN
            tmo_cnt_q  <= tmo_cnt_d;
`endif
        end
    end

    assign br_n    = br_n_q;
    assign bgack_n = bgack_n_q;
    assign as_n    = as_n_q;
    assign uds_n   = uds_n_q;
    assign lds_n   = lds_n_q;
    assign rw      = rw_q;
    assign fc      = fc_q;
    assign a       = a_q;
    assign d_out   = d_out_q;
    assign bus_oe  = bus_oe_q;
    assign d_oe    = d_oe_q;
    assign ack     = ack_q;
    assign err     = err_q;
    assign rdata   = rdata_q;

endmodule

// File: tb/tb_m68k_bus_master.sv
// Self-checking bench for m68k_bus_master: CPU arbiter and slave models plus a
// transaction-level reference for strobes, data, error and latency.
module tb_m68k_bus_master;

    logic        clk;
    logic        reset_n;
    logic        req, we;
    logic [22:0] addr;
    logic [1:0]  be;
    logic [15:0] wdata;
    logic        ack, err;
    logic [15:0] rdata;
    logic        br_n, bg_n, bgack_n;
    logic        as_n, uds_n, lds_n, rw;
    logic [2:0]  fc;
    logic [22:0] a;
    logic [15:0] d_out, d_in;
    logic        bus_oe, d_oe;
    logic        as_in_n, dtack_n, berr_n;

    int          checks;
    int          failures;
    logic [15:0] exp_rdata;
    int          slave_mode;   // 0: DTACK, 1: BERR+DTACK together, 2: no reply
    logic [15:0] slave_data;
    logic        cpu_as_n;

    int          br_falls, bgack_falls, ack_cnt, ack_double, overlap_cnt;

    localparam logic [67:0] RESET_VEC = {6'b111111, 62'd0};
    localparam int          TMO_CYC   = 64;
    logic [67:0] outs_w;
    assign outs_w = {br_n, bgack_n, as_n, uds_n, lds_n, rw, fc, a, d_out,
                     bus_oe, d_oe, ack, err, rdata};

    m68k_bus_master dut (
        .clk(clk), .reset_n(reset_n), .req(req), .we(we), .addr(addr), .be(be),
        .wdata(wdata), .ack(ack), .err(err), .rdata(rdata), .br_n(br_n),
        .bg_n(bg_n), .bgack_n(bgack_n), .as_n(as_n), .uds_n(uds_n), .lds_n(lds_n),
        .rw(rw), .fc(fc), .a(a), .d_out(d_out), .d_in(d_in), .bus_oe(bus_oe),
        .d_oe(d_oe), .as_in_n(as_in_n), .dtack_n(dtack_n), .berr_n(berr_n)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // CPU grants whenever requested; slave replies while our strobe is low.
    initial begin
        bg_n = 1'b1; as_in_n = 1'b1; dtack_n = 1'b1; berr_n = 1'b1; d_in = 16'd0;
        forever begin
            @(negedge clk);
            bg_n    = br_n;
            as_in_n = cpu_as_n & (bus_oe ? as_n : 1'b1);
            dtack_n = !(bus_oe && !as_n && slave_mode != 2);
            berr_n  = !(bus_oe && !as_n && slave_mode == 1);
            d_in    = slave_data;
        end
    end

    // Event counters for handshake, ack pulse width and strobe overlap.
    initial begin
        logic p_br, p_bgack, p_ack;
        br_falls = 0; bgack_falls = 0; ack_cnt = 0; ack_double = 0; overlap_cnt = 0;
        p_br = 1'b1; p_bgack = 1'b1; p_ack = 1'b0;
        forever begin
            @(negedge clk);
            if (reset_n) begin
                if (p_br && !br_n) br_falls++;
                if (p_bgack && !bgack_n) bgack_falls++;
                if (ack) ack_cnt++;
                if (ack && p_ack) ack_double++;
                if (!cpu_as_n && !as_n) overlap_cnt++;
            end
            p_br = br_n; p_bgack = bgack_n; p_ack = ack;
        end
    end

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    task automatic run_xfer(input logic w, input logic [22:0] ad, input logic [1:0] b,
                            input logic [15:0] wd, input logic [15:0] sd, input int mode,
                            input bit hold_req, output int lat);
        logic [1:0]  be_eff;
        logic [22:0] p_a, s_a;
        logic        p_rw, p_doe, s_uds, s_lds, s_rw, s_doe, r_doe;
        logic [2:0]  s_fc;
        logic [15:0] s_dout;
        bit          seen, rose, got_ack, gnt_seen;
        int          gnt_cnt;
        be_eff = (b == 2'b00) ? 2'b11 : b;
        we = w; addr = ad; be = b; wdata = wd; slave_data = sd; slave_mode = mode; req = 1'b1;
        seen = 0; rose = 0; got_ack = 0; gnt_seen = 0; gnt_cnt = 0; lat = -1;
        p_a = '0; p_rw = 1'b1; p_doe = 1'b0; r_doe = 1'b0;
        s_a = '0; s_uds = 1'b1; s_lds = 1'b1; s_rw = 1'b1; s_doe = 1'b0; s_fc = '0; s_dout = '0;
        for (int i = 0; i < 300 && !got_ack; i++) begin
            @(negedge clk);
            if (seen && !rose && as_n) begin rose = 1; r_doe = d_oe; end
            if (!as_n && !seen) begin
                seen = 1; s_a = a; s_uds = uds_n; s_lds = lds_n; s_rw = rw;
                s_fc = fc; s_dout = d_out; s_doe = d_oe;
            end
            if (gnt_seen) gnt_cnt++;
            if (!bgack_n) gnt_seen = 1;
            if (ack) got_ack = 1;
            if (!seen) begin p_a = a; p_rw = rw; p_doe = d_oe; end
        end
        if (!hold_req) req = 1'b0;
        lat = gnt_cnt;
        checks++;
        if (!got_ack || !seen) begin
            failures++;
            $display("FAIL xfer_done: ack=%0b strobe_seen=%0b required 1/1", got_ack, seen);
            return;
        end
        if (!w && mode == 0) exp_rdata = sd;
        checks++;
        if (err !== (mode != 0)) begin failures++; $display("FAIL err: got %0b expected %0b", err, (mode != 0)); end
        checks++;
        if (rdata !== exp_rdata) begin failures++; $display("FAIL rdata: got %h expected %h", rdata, exp_rdata); end
        checks++;
        if ({s_uds, s_lds} !== ~be_eff) begin failures++; $display("FAIL strobes: got %b expected %b", {s_uds, s_lds}, ~be_eff); end
        checks++;
        if ({s_rw, s_fc, s_a} !== {~w, 3'b101, ad}) begin
            failures++; $display("FAIL addr_phase: got rw=%b fc=%b a=%h expected rw=%b fc=101 a=%h", s_rw, s_fc, s_a, ~w, ad);
        end
        checks++;
        if ({p_rw, p_a} !== {~w, ad}) begin failures++; $display("FAIL addr_setup: got rw=%b a=%h expected rw=%b a=%h", p_rw, p_a, ~w, ad); end
        checks++;
        if (as_n !== 1'b1 || d_oe !== 1'b0) begin failures++; $display("FAIL end_state: got as_n=%b d_oe=%b expected 1 0", as_n, d_oe); end
        if (w) begin
            checks++;
            if ({s_doe, s_dout, p_doe, r_doe} !== {1'b1, wd, 1'b1, 1'b1}) begin
                failures++; $display("FAIL wdata: got oe=%b d=%h setup_oe=%b hold_oe=%b expected 1 %h 1 1", s_doe, s_dout, p_doe, r_doe, wd);
            end
        end
    endtask

    task automatic test_reset;
        reset_n = 1'b0;
        idle(3);
        checks++;
        if (outs_w !== RESET_VEC) begin failures++; $display("FAIL reset_vals: got %h expected %h", outs_w, RESET_VEC); end
        reset_n = 1'b1;
        idle(3);
        checks++;
        if (outs_w !== RESET_VEC) begin failures++; $display("FAIL idle_vals: got %h expected %h", outs_w, RESET_VEC); end
    endtask

    task automatic test_word_read;
        int lat;
        idle(4);
        run_xfer(1'b0, 23'h000100, 2'b11, 16'h0000, 16'hBEEF, 0, 1'b0, lat);
        checks++;
        if (lat !== 6) begin failures++; $display("FAIL read_latency: got %0d expected 6", lat); end
    endtask

    task automatic test_byte_write;
        int lat;
        idle(4);
        run_xfer(1'b1, 23'h760000, 2'b01, 16'h00A5, 16'h1234, 0, 1'b0, lat);
        checks++;
        if (lat !== 6) begin failures++; $display("FAIL write_latency: got %0d expected 6", lat); end
    endtask

    task automatic test_bus_error;
        int lat;
        idle(4);
        run_xfer(1'b0, 23'($urandom), 2'b10, 16'h0000, 16'h5555, 1, 1'b0, lat);
        checks++;
        if (lat !== 6) begin failures++; $display("FAIL berr_latency: got %0d expected 6", lat); end
    endtask

    task automatic test_back_to_back;
        int lat, b0, g0, k0;
        idle(4);
        b0 = br_falls; g0 = bgack_falls; k0 = ack_cnt;
        run_xfer(1'b0, 23'h000200, 2'b11, 16'h0000, 16'hA001, 0, 1'b1, lat);
        run_xfer(1'b1, 23'h000201, 2'b10, 16'hC3C3, 16'h0000, 0, 1'b1, lat);
        run_xfer(1'b0, 23'h000202, 2'b00, 16'h0000, 16'hA003, 0, 1'b0, lat);
        idle(3);
        checks++;
        if (br_falls - b0 !== 1 || bgack_falls - g0 !== 1) begin
            failures++; $display("FAIL b2b_handshake: got br=%0d bgack=%0d expected 1 1", br_falls - b0, bgack_falls - g0);
        end
        checks++;
        if (ack_cnt - k0 !== 3) begin failures++; $display("FAIL b2b_acks: got %0d expected 3", ack_cnt - k0); end
        checks++;
        if ({bgack_n, bus_oe, br_n} !== 3'b101) begin failures++; $display("FAIL b2b_release: got %b expected 101", {bgack_n, bus_oe, br_n}); end
    endtask

    task automatic test_grant_busy;
        int lat, bad;
        idle(4);
        cpu_as_n = 1'b0;
        we = 1'b0; addr = 23'h012345; be = 2'b11; slave_data = 16'h7E57; slave_mode = 0; req = 1'b1;
        bad = 0;
        idle(3);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (!bgack_n || !as_n || br_n || bus_oe) bad++;
        end
        checks++;
        if (bad !== 0) begin failures++; $display("FAIL busy_wait: got %0d bad cycles expected 0", bad); end
        cpu_as_n = 1'b1;
        run_xfer(1'b0, 23'h012345, 2'b11, 16'h0000, 16'h7E57, 0, 1'b0, lat);
        checks++;
        if (overlap_cnt !== 0) begin failures++; $display("FAIL strobe_overlap: got %0d expected 0", overlap_cnt); end
    endtask

    task automatic test_random;
        int  lat;
        bit  prev_hold, hold;
        logic w;
        prev_hold = 0;
        for (int i = 0; i < 24; i++) begin
            if (!prev_hold) idle(4);
            hold = (i != 23) && ($urandom_range(0, 1) == 1);
            w = 1'($urandom_range(0, 1));
            run_xfer(w, 23'($urandom), 2'($urandom_range(0, 3)), 16'($urandom), 16'($urandom),
                     ($urandom_range(0, 3) == 0) ? 1 : 0, hold, lat);
            if (!prev_hold) begin
                checks++;
                if (lat !== 6) begin failures++; $display("FAIL rand_latency[%0d]: got %0d expected 6", i, lat); end
            end
            prev_hold = hold;
        end
    endtask

`ifdef M68K_BUS_MASTER_TIMEOUT_EN
    task automatic test_timeout;
        int lat;
        idle(4);
        run_xfer(1'b0, 23'h3FFFFF, 2'b11, 16'h0000, 16'hDEAD, 2, 1'b0, lat);
        checks++;
        if (lat !== TMO_CYC + 4) begin failures++; $display("FAIL timeout_latency: got %0d expected %0d", lat, TMO_CYC + 4); end
    endtask
`endif

    task automatic test_reset_mid;
        int lat;
        bit found;
        idle(4);
        we = 1'b1; addr = 23'h055AA5; be = 2'b11; wdata = 16'hF00D; slave_mode = 2; req = 1'b1;
        found = 0;
        for (int i = 0; i < 50 && !found; i++) begin
            @(negedge clk);
            if (!as_n) found = 1;
        end
        checks++;
        if (!found) begin failures++; $display("FAIL mid_strobe: got no strobe expected as_n=0"); end
        idle(3);
        reset_n = 1'b0;
        #1;
        checks++;
        if (outs_w !== RESET_VEC) begin failures++; $display("FAIL mid_reset_vals: got %h expected %h", outs_w, RESET_VEC); end
        req = 1'b0; slave_mode = 0; exp_rdata = 16'h0000;
        @(negedge clk);
        reset_n = 1'b1;
        idle(3);
        run_xfer(1'b0, 23'h000004, 2'b11, 16'h0000, 16'h1357, 0, 1'b0, lat);
        checks++;
        if (lat !== 6) begin failures++; $display("FAIL recover_latency: got %0d expected 6", lat); end
    endtask

    task automatic test_ack_pulse;
        checks++;
        if (ack_double !== 0) begin failures++; $display("FAIL ack_width: got %0d long pulses expected 0", ack_double); end
    endtask

    initial begin
        checks = 0; failures = 0; exp_rdata = 16'h0000;
        reset_n = 1'b0; req = 1'b0; we = 1'b0; addr = 23'd0; be = 2'b00; wdata = 16'd0;
        cpu_as_n = 1'b1; slave_mode = 0; slave_data = 16'd0;
        test_reset();
        test_word_read();
        test_byte_write();
        test_bus_error();
        test_back_to_back();
        test_grant_busy();
        test_random();
`ifdef M68K_BUS_MASTER_TIMEOUT_EN
        test_timeout();
`endif
        test_reset_mid();
        test_ack_pulse();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/m68k_bus_master.md
# m68k_bus_master

Synchronous 68000-bus initiator that lets an on-board DMA/test engine take ownership of the CPU bus and run word/byte read and write cycles against the same address map the glue logic decodes. It arbitrates with the CPU through BR/BG/BGACK, drives AS/UDS/LDS/RW/FC/address/data while it is bus master, and completes each cycle on DTACK or aborts it on BERR. It sits beside the CPU on the system bus; the glue logic sees it as an ordinary bus cycle source.

## Interface
- `TIMEOUT_CYCLES`, 64, clocks allowed in WAIT before a local abort (only with the macro).
- `FC_CODE`, 3'b101, function code driven during owned cycles (supervisor data).
- `clk` in 1: system clock; all logic on its rising edge.
- `reset_n` in 1: reset, asynchronous and active-low.
- `req` in 1: start a transfer; sampled in IDLE/HOLD.
- `we` in 1: 1 = write, 0 = read.
- `addr` in 23: word address A23..A1.
- `be` in 2: byte enables {upper, lower}; 2'b00 is illegal (treated as 2'b11).
- `wdata` in 16: write data.
- `ack` out 1: one-cycle pulse, transfer finished (good or error).
- `err` out 1: valid with `ack`; 1 = BERR or timeout.
- `rdata` out 16: read data, valid with `ack`, held until next `ack`.
- `br_n` out 1, `bg_n` in 1, `bgack_n` out 1: bus arbitration.
- `as_n`, `uds_n`, `lds_n`, `rw` out 1 each; `fc` out 3; `a` out 23; `d_out` out 16; `d_in` in 16.
- `bus_oe` out 1: 1 while the block owns the bus (enables external tri-state drivers for as/ds/rw/fc/a).
- `d_oe` out 1: 1 while write data is driven.
- `as_in_n`, `dtack_n`, `berr_n` in 1: bus-side observations.

## Operation
- `bg_n`, `as_in_n`, `dtack_n`, `berr_n` pass through two-flop synchronizers; all decisions use synchronized values.
- States: IDLE, REQ, GRANT, S_ADDR, S_STRB, S_WAIT, S_END, HOLD.
- IDLE: `req`=1 → latch we/addr/be/wdata, assert `br_n`=0, go REQ.
- REQ: wait `bg_n`=0 and `as_in_n`=1 and `dtack_n`=1 → GRANT.
- GRANT: `bgack_n`=0, `br_n`=1, `bus_oe`=1 → S_ADDR.
- S_ADDR: drive `a`, `fc`=FC_CODE, `rw`=~we; on write `d_oe`=1, `d_out`=wdata → S_STRB.
- S_STRB: `as_n`=0; `uds_n`/`lds_n` = ~be bits (reads and writes both assert strobes here) → S_WAIT.
- S_WAIT: `berr_n`=0 → S_END with error (BERR wins over simultaneous DTACK); else `dtack_n`=0 → S_END, capture `d_in` into `rdata` on reads.
- S_END: negate `as_n`/`uds_n`/`lds_n`, pulse `ack`; next cycle `d_oe`=0 → HOLD.
- HOLD: `req`=1 → latch new request, S_ADDR (keeps bus, no rearbitration); `req`=0 → negate `bgack_n`, `bus_oe`=0, IDLE.
- `req` is ignored outside IDLE/HOLD; the requester keeps fields stable until `ack`.
- Reset mid-cycle: all outputs return to reset values immediately (asynchronous); bus released without completing the cycle.

## Timing
- Reset values: `br_n`=1, `bgack_n`=1, `as_n`=`uds_n`=`lds_n`=1, `rw`=1, `fc`=0, `a`=0, `d_out`=0, `bus_oe`=0, `d_oe`=0, `ack`=0, `err`=0, `rdata`=0; state IDLE.
- All outputs registered.
- Minimum transfer from bus-granted (synchronized `bg_n`) to `ack`: GRANT, S_ADDR, S_STRB, S_WAIT + 2-cycle dtack sync, S_END → `ack` 6 clocks after entering GRANT when slave holds DTACK low.
- Address/RW/FC stable one full clock before `as_n` falls and until `as_n` rises.
- Write data valid one clock before strobes and held one clock after.

## Configuration
- `M68K_BUS_MASTER_TIMEOUT_EN` defined: counter in S_WAIT; after `TIMEOUT_CYCLES` clocks without DTACK/BERR → S_END with `err`=1.
- Undefined: S_WAIT waits indefinitely; only the external watchdog (BERR) aborts a stuck cycle.

## Structure
- Shared package/header: state encoding constants, FC codes (user/supervisor data/program, 3'b111 IACK) shared with the glue logic.
- One sub-module: `sync2`, two-flop synchronizer with asynchronous active-low reset, instantiated per bus input (reset value 1).

## Test plan
- Word read: req, we=0, addr=23'h000100, be=2'b11; arbiter grants; slave DTACK with d_in=16'hBEEF → `ack`, err=0, rdata=16'hBEEF; uds_n=lds_n=0 during strobe.
- Byte write: we=1, addr=23'h760000, be=2'b01, wdata=16'h00A5 → uds_n=1, lds_n=0, rw=0, d_out=16'h00A5, `ack` with err=0.
- Bus error: BERR and DTACK asserted same cycle → `ack` with err=1, rdata unchanged.
- Back-to-back: req held for 3 transfers → one br_n/bgack_n handshake, 3 `ack` pulses, bgack_n released after last.
- Grant while CPU cycle active (as_in_n=0) → block stays in REQ until as_in_n=1, no overlap of strobes.
- Timeout (macro on, TIMEOUT_CYCLES=64): no DTACK → `ack` with err=1 after 64 clocks in S_WAIT; reset_n pulsed mid-wait → all outputs at reset values next sample.
